// File: rtl/id_stage.sv
// Instruction-decode front end: IF/ID register, PC shadowing, immediate
// decode and in-ID resolution of conditional branches, JAL and JALR under
// static predict-not-taken, with the fetch redirect/squash handshake.
//
// state | meaning
// ------+-----------------------------------------------------------------
// RUN   | normal flow; a taken transfer in ID raises incorrect for a cycle
// SQ    | one squash cycle: stall fetch, load fetch PC with latched target
module id_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst,
   output logic [4:0]  rs1_addr,
   output logic [4:0]  rs2_addr,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   output logic        stall,
   output logic        incorrect,
   output logic [31:0] imm32,
   output logic        id_valid,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc,
   output logic [31:0] id_imm,
   output logic [31:0] id_link
);

   typedef enum logic {S_RUN = 1'b0, S_SQ = 1'b1} state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   state_t      state_q, state_d;
   logic [31:0] fpc_q, fpc_d;
   logic [31:0] id_inst_q, id_inst_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] tgt_q, tgt_d;
   logic        id_valid_q, id_valid_d;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] jalr_tgt;
   logic [31:0] offset;
   logic        br_cond;
   logic        taken;

   assign opcode   = id_inst_q[6:0];
   assign funct3   = id_inst_q[14:12];
   assign rs1_addr = id_inst_q[19:15];
   assign rs2_addr = id_inst_q[24:20];

   assign imm_i = {{20{id_inst_q[31]}}, id_inst_q[31:20]};
   assign imm_s = {{20{id_inst_q[31]}}, id_inst_q[31:25], id_inst_q[11:7]};
   assign imm_b = {{19{id_inst_q[31]}}, id_inst_q[31], id_inst_q[7],
                   id_inst_q[30:25], id_inst_q[11:8], 1'b0};
   assign imm_u = {id_inst_q[31:12], 12'h000};
   assign imm_j = {{11{id_inst_q[31]}}, id_inst_q[31], id_inst_q[19:12],
                   id_inst_q[20], id_inst_q[30:21], 1'b0};

   // Immediate format chosen by opcode; R-type and unknown opcodes give 0
   always_comb begin
      id_imm = 32'h0;
      case (opcode)
         OP_LOAD, OP_IMM, OP_JALR: id_imm = imm_i;
         OP_STORE:                 id_imm = imm_s;
         OP_BRANCH:                id_imm = imm_b;
         OP_LUI, OP_AUIPC:         id_imm = imm_u;
         OP_JAL:                   id_imm = imm_j;
         default:                  id_imm = 32'h0;
      endcase
   end

   // Conditional-branch compare; funct3 010/011 never resolve taken
   always_comb begin
      br_cond = 1'b0;
      case (funct3)
         3'b000:  br_cond = (rs1_data == rs2_data);
         3'b001:  br_cond = (rs1_data != rs2_data);
         3'b100:  br_cond = ($signed(rs1_data) <  $signed(rs2_data));
         3'b101:  br_cond = ($signed(rs1_data) >= $signed(rs2_data));
         3'b110:  br_cond = (rs1_data <  rs2_data);
         3'b111:  br_cond = (rs1_data >= rs2_data);
         default: br_cond = 1'b0;
      endcase
   end

   // JALR offset is reported relative to the branch PC so fetch can use one adder
   assign jalr_tgt = (rs1_data + imm_i) & 32'hFFFF_FFFE;

   // Taken decision; a bubble or the squash cycle never redirects
   always_comb begin
      taken  = 1'b0;
      offset = 32'h0;
      if (id_valid_q && (state_q == S_RUN)) begin
         case (opcode)
            OP_BRANCH: begin
               taken  = br_cond;
               offset = imm_b;
            end
            OP_JAL: begin
               taken  = 1'b1;
               offset = imm_j;
            end
            OP_JALR: begin
               taken  = 1'b1;
               offset = jalr_tgt - id_pc_q;
            end
            default: begin
               taken  = 1'b0;
               offset = 32'h0;
            end
         endcase
      end
   end

   assign incorrect = taken;
   assign imm32     = taken ? offset : 32'h0;
   assign stall     = (state_q == S_SQ);

   assign id_valid  = id_valid_q;
   assign id_inst   = id_inst_q;
   assign id_pc     = id_pc_q;
   assign id_link   = id_pc_q + 32'd4;

   // Next-state: capture every cycle, squash two slots after a redirect
   always_comb begin
      state_d    = state_q;
      fpc_d      = fpc_q + 32'd4;
      tgt_d      = tgt_q;
      id_valid_d = 1'b1;
      id_inst_d  = inst;
      id_pc_d    = fpc_q;
      case (state_q)
         S_RUN: begin
            if (taken) begin
               id_valid_d = 1'b0;
               tgt_d      = (id_pc_q + offset) & 32'hFFFF_FFFC;
               state_d    = S_SQ;
            end
         end
         S_SQ: begin
            id_valid_d = 1'b0;
            fpc_d      = tgt_q;
            state_d    = S_RUN;
         end
      endcase
   end

   // State and pipeline registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_RUN;
         fpc_q      <= RESET_PC;
         id_inst_q  <= 32'h0;
         id_pc_q    <= 32'h0;
         id_valid_q <= 1'b0;
         tgt_q      <= 32'h0;
      end else begin
         state_q    <= state_d;
         fpc_q      <= fpc_d;
         id_inst_q  <= id_inst_d;
         id_pc_q    <= id_pc_d;
         id_valid_q <= id_valid_d;
         tgt_q      <= tgt_d;
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: program memory with semantic annotations, a fetch
// model honouring the redirect contract, and an ISA-level reference model
// of what ID must hold and report each cycle.
module tb_id_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] inst = 32'h0;
   logic [4:0]  rs1_addr, rs2_addr;
   logic [31:0] rs1_data, rs2_data;
   logic        stall, incorrect, id_valid;
   logic [31:0] imm32, id_inst, id_pc, id_imm, id_link;

   id_stage #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .inst(inst),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .stall(stall), .incorrect(incorrect), .imm32(imm32),
      .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
      .id_imm(id_imm), .id_link(id_link)
   );

   always #5 clk = ~clk;

   logic [31:0] regs [32];
   assign rs1_data = (rs1_addr == 5'd0) ? 32'h0 : regs[rs1_addr];
   assign rs2_data = (rs2_addr == 5'd0) ? 32'h0 : regs[rs2_addr];

   // kind: 0 other, 1 conditional branch, 2 JAL, 3 JALR
   typedef struct {
      logic [31:0] w;
      logic [31:0] imm;
      int          kind;
      logic [2:0]  f3;
      int          rs1;
      int          rs2;
   } ent_t;

   ent_t prog [256];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc;
   int first_valid;
   int stall_cnt;
   logic [31:0] vpcs[$];
   logic [31:0] imms[$];
   logic [31:0] links[$];
   logic [31:0] expq[$];

   // reference model state
   logic [31:0] m_pc, m_fpc, m_tgt;
   ent_t        m_ent;
   logic        m_valid, m_stall;

   function automatic ent_t blank();
      ent_t e;
      e.w = 32'h0; e.imm = 32'h0; e.kind = 0; e.f3 = 3'b000; e.rs1 = 0; e.rs2 = 0;
      return e;
   endfunction

   function automatic ent_t e_addi(logic [31:0] rd, logic [31:0] rs1, logic [31:0] imm);
      ent_t e = blank();
      e.w   = {imm[11:0], rs1[4:0], 3'b000, rd[4:0], 7'b0010011};
      e.imm = imm;
      return e;
   endfunction

   function automatic ent_t e_lui(logic [31:0] rd, logic [31:0] u);
      ent_t e = blank();
      e.w   = {u[19:0], rd[4:0], 7'b0110111};
      e.imm = {u[19:0], 12'h000};
      return e;
   endfunction

   function automatic ent_t e_sw(logic [31:0] rs2, logic [31:0] rs1, logic [31:0] imm);
      ent_t e = blank();
      e.w   = {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
      e.imm = imm;
      return e;
   endfunction

   function automatic ent_t e_add(logic [31:0] rd, logic [31:0] rs1, logic [31:0] rs2);
      ent_t e = blank();
      e.w = {7'b0000000, rs2[4:0], rs1[4:0], 3'b000, rd[4:0], 7'b0110011};
      return e;
   endfunction

   function automatic ent_t e_br(logic [2:0] f3, logic [31:0] rs1, logic [31:0] rs2,
                                 logic [31:0] imm);
      ent_t e = blank();
      e.w    = {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3, imm[4:1], imm[11], 7'b1100011};
      e.imm  = imm;
      e.kind = 1;
      e.f3   = f3;
      e.rs1  = int'(rs1[4:0]);
      e.rs2  = int'(rs2[4:0]);
      return e;
   endfunction

   function automatic ent_t e_jal(logic [31:0] rd, logic [31:0] imm);
      ent_t e = blank();
      e.w    = {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
      e.imm  = imm;
      e.kind = 2;
      return e;
   endfunction

   function automatic ent_t e_jalr(logic [31:0] rd, logic [31:0] rs1, logic [31:0] imm);
      ent_t e = blank();
      e.w    = {imm[11:0], rs1[4:0], 3'b000, rd[4:0], 7'b1100111};
      e.imm  = imm;
      e.kind = 3;
      e.rs1  = int'(rs1[4:0]);
      return e;
   endfunction

   function automatic logic [31:0] rd_reg(int i);
      return (i == 0) ? 32'h0 : regs[i];
   endfunction

   task automatic put(logic [31:0] addr, ent_t e);
      prog[addr[9:2]] = e;
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) prog[i] = blank();
      for (int i = 0; i < 32; i++) regs[i] = 32'h0;
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cmp_q(string name, logic [31:0] got[$], logic [31:0] exp[$]);
      for (int i = 0; i < exp.size(); i++)
         chk($sformatf("%s[%0d]", name, i), (i < got.size()) ? got[i] : 32'hDEAD_BEEF, exp[i]);
   endtask

   // Architectural view: does the instruction in ID transfer control, and by how much
   task automatic model_eval(output logic tk, output logic [31:0] off);
      logic [31:0] a, b;
      tk  = 1'b0;
      off = 32'h0;
      a   = rd_reg(m_ent.rs1);
      b   = rd_reg(m_ent.rs2);
      if (m_valid && !m_stall) begin
         case (m_ent.kind)
            1: begin
               case (m_ent.f3)
                  3'b000:  tk = (a == b);
                  3'b001:  tk = (a != b);
                  3'b100:  tk = ($signed(a) <  $signed(b));
                  3'b101:  tk = ($signed(a) >= $signed(b));
                  3'b110:  tk = (a <  b);
                  3'b111:  tk = (a >= b);
                  default: tk = 1'b0;
               endcase
               off = m_ent.imm;
            end
            2: begin tk = 1'b1; off = m_ent.imm; end
            3: begin tk = 1'b1; off = ((a + m_ent.imm) & 32'hFFFF_FFFE) - m_pc; end
            default: ;
         endcase
      end
      if (!tk) off = 32'h0;
   endtask

   task automatic do_reset();
      rst     = 1'b0;
      m_pc    = 32'h0;
      m_ent   = blank();
      m_valid = 1'b0;
      m_stall = 1'b0;
      m_tgt   = 32'h0;
      m_fpc   = RESET_PC;
      repeat (2) @(posedge clk);
      #1;
      rst         = 1'b1;
      cyc         = 0;
      first_valid = -1;
      stall_cnt   = 0;
      vpcs.delete();
      imms.delete();
      links.delete();
   endtask

   // One clock: drive fetch word, compare DUT against model, advance model
   task automatic step();
      logic        tk;
      logic [31:0] off, old_pc;
      ent_t        fe;
      @(negedge clk);
      cyc++;
      fe   = m_stall ? blank() : prog[m_fpc[9:2]];
      inst = fe.w;
      model_eval(tk, off);
      chk("id_valid",  32'(id_valid),  32'(m_valid));
      chk("id_pc",     id_pc,          m_pc);
      chk("id_inst",   id_inst,        m_ent.w);
      chk("id_imm",    id_imm,         m_ent.imm);
      chk("id_link",   id_link,        m_pc + 32'd4);
      chk("rs1_addr",  32'(rs1_addr),  32'(m_ent.w[19:15]));
      chk("rs2_addr",  32'(rs2_addr),  32'(m_ent.w[24:20]));
      chk("stall",     32'(stall),     32'(m_stall));
      chk("incorrect", 32'(incorrect), 32'(tk));
      chk("imm32",     imm32,          off);
      if (id_valid) begin
         vpcs.push_back(id_pc);
         if (first_valid < 0) first_valid = cyc;
      end
      if (incorrect) begin
         imms.push_back(imm32);
         links.push_back(id_link);
      end
      if (stall) stall_cnt++;
      @(posedge clk);
      old_pc  = m_pc;
      m_pc    = m_fpc;
      m_ent   = fe;
      m_valid = !tk && !m_stall;
      if (m_stall) begin
         m_fpc   = m_tgt;
         m_stall = 1'b0;
      end else begin
         if (tk) begin
            m_tgt   = (old_pc + off) & 32'hFFFF_FFFC;
            m_stall = 1'b1;
         end
         m_fpc = m_fpc + 32'd4;
      end
   endtask

   task automatic load_beq_prog(logic [31:0] x1, logic [31:0] x2);
      clear_prog();
      regs[1] = x1;
      regs[2] = x2;
      put(32'd0,  e_addi(3, 0, 1));
      put(32'd4,  e_addi(4, 0, 2));
      put(32'd8,  e_br(3'b000, 1, 2, 16));
      put(32'd12, e_addi(7, 0, 12));
      put(32'd16, e_addi(8, 0, 16));
      put(32'd20, e_addi(9, 0, 20));
      put(32'd24, e_addi(10, 0, 24));
      put(32'd28, e_addi(11, 0, 28));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- straight-line stream after reset ----
      clear_prog();
      put(32'd0,  e_addi(1, 0, 1));
      put(32'd4,  e_addi(2, 0, 2));
      put(32'd8,  e_addi(3, 1, -1));
      put(32'd12, e_addi(4, 0, 32'h7FF));
      put(32'd16, e_lui(5, 32'h80001));
      put(32'd20, e_sw(2, 1, -4));
      put(32'd24, e_add(6, 1, 2));
      do_reset();
      repeat (9) step();
      chk("s1_first_valid", 32'(first_valid), 32'd2);
      expq = '{32'd0, 32'd4, 32'd8, 32'd12};
      cmp_q("s1_vpc", vpcs, expq);
      chk("s1_no_redirect", 32'(imms.size()), 32'd0);
      chk("s1_no_stall", 32'(stall_cnt), 32'd0);

      // ---- BEQ taken, x1 == x2 ----
      load_beq_prog(32'd5, 32'd5);
      do_reset();
      repeat (10) step();
      expq = '{32'd0, 32'd4, 32'd8, 32'd24, 32'd28};
      cmp_q("s2_vpc", vpcs, expq);
      chk("s2_nredir", 32'(imms.size()), 32'd1);
      expq = '{32'd16};
      cmp_q("s2_imm32", imms, expq);
      chk("s2_stall_cycles", 32'(stall_cnt), 32'd1);

      // ---- BEQ not taken ----
      load_beq_prog(32'd5, 32'd6);
      do_reset();
      repeat (6) step();
      expq = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16};
      cmp_q("s3_vpc", vpcs, expq);
      chk("s3_nredir", 32'(imms.size()), 32'd0);

      // ---- BLT taken, BLTU not taken on the same operands ----
      clear_prog();
      regs[1] = 32'hFFFF_FFFF;
      regs[2] = 32'd1;
      put(32'd0,  e_addi(3, 0, 1));
      put(32'd4,  e_addi(4, 0, 2));
      put(32'd8,  e_br(3'b100, 1, 2, 16));
      put(32'd12, e_addi(7, 0, 1));
      put(32'd16, e_addi(8, 0, 1));
      put(32'd20, e_addi(9, 0, 1));
      put(32'd24, e_br(3'b110, 1, 2, 16));
      put(32'd28, e_addi(10, 0, 1));
      put(32'd32, e_addi(11, 0, 1));
      do_reset();
      repeat (11) step();
      expq = '{32'd0, 32'd4, 32'd8, 32'd24, 32'd28, 32'd32};
      cmp_q("s4_vpc", vpcs, expq);
      chk("s4_nredir", 32'(imms.size()), 32'd1);

      // ---- JAL, BGE/BGEU, funct3 010, backward BNE ----
      clear_prog();
      regs[1] = 32'hFFFF_FFFF;
      regs[2] = 32'd1;
      put(32'd0,  e_jal(0, 12));
      put(32'd4,  e_addi(3, 0, 4));
      put(32'd8,  e_addi(3, 0, 8));
      put(32'd12, e_br(3'b101, 1, 2, 40));
      put(32'd16, e_br(3'b111, 1, 2, 8));
      put(32'd20, e_addi(3, 0, 20));
      put(32'd24, e_br(3'b010, 1, 2, 8));
      put(32'd28, e_br(3'b001, 1, 2, -28));
      do_reset();
      repeat (16) step();
      expq = '{32'd0, 32'd12, 32'd16, 32'd24, 32'd28, 32'd0};
      cmp_q("s5_vpc", vpcs, expq);
      expq = '{32'd12, 32'd8, 32'hFFFF_FFE4};
      cmp_q("s5_imm32", imms, expq);

      // ---- JALR x0,4(x5) at PC 40 ----
      clear_prog();
      regs[5] = 32'h0000_0103;
      for (int a = 0; a < 40; a += 4) put(32'(a), e_addi(0, 0, 0));
      put(32'd40,  e_jalr(0, 5, 4));
      put(32'd44,  e_addi(6, 0, 44));
      put(32'd48,  e_addi(6, 0, 48));
      put(32'h104, e_addi(7, 0, 1));
      put(32'h108, e_addi(8, 0, 2));
      do_reset();
      repeat (16) step();
      expq = '{};
      for (int a = 0; a <= 40; a += 4) expq.push_back(32'(a));
      expq.push_back(32'h104);
      expq.push_back(32'h108);
      cmp_q("s6_vpc", vpcs, expq);
      expq = '{32'h0000_00DE};
      cmp_q("s6_imm32", imms, expq);
      expq = '{32'd44};
      cmp_q("s6_link", links, expq);

      // ---- reset pulse during the squash cycle ----
      load_beq_prog(32'd5, 32'd5);
      do_reset();
      repeat (4) step();
      #2;
      chk("s7_stall_in_sq", 32'(stall), 32'd1);
      rst = 1'b0;
      #1;
      chk("s7_rst_stall",     32'(stall),     32'd0);
      chk("s7_rst_incorrect", 32'(incorrect), 32'd0);
      chk("s7_rst_imm32",     imm32,          32'd0);
      chk("s7_rst_valid",     32'(id_valid),  32'd0);
      chk("s7_rst_pc",        id_pc,          32'd0);
      chk("s7_rst_inst",      id_inst,        32'd0);
      do_reset();
      repeat (3) step();
      chk("s7_first_valid", 32'(first_valid), 32'd2);
      expq = '{RESET_PC, RESET_PC + 32'd4};
      cmp_q("s7_vpc", vpcs, expq);
      chk("s7_nredir", 32'(imms.size()), 32'd0);
      chk("s7_no_stall", 32'(stall_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode front end that sits directly downstream of the fetch stage. It captures each fetched word into the IF/ID register and keeps a shadow copy of the fetch address so every instruction carries its PC. It decodes the immediate and resolves conditional branches, JAL and JALR in ID under static predict-not-taken. On a taken control transfer it drives the fetch redirect (`incorrect`, `imm32`) and the fetch `stall` that squashes wrong-path words.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: address of the first word fetch delivers after reset.

Ports:
- `clk`, in, 1: single clock; all state updates on posedge.
- `rst`, in, 1: asynchronous, active-low reset.
- `inst`, in, 32: word from fetch; reads 0 while `stall`=1.
- `rs1_addr`, out, 5: `id_inst[19:15]`, combinational, to register file.
- `rs2_addr`, out, 5: `id_inst[24:20]`, combinational, to register file.
- `rs1_data`, in, 32: register file read data for `rs1_addr` (x0 reads 0).
- `rs2_data`, in, 32: register file read data for `rs2_addr`.
- `stall`, out, 1: to fetch; forces fetch output to 0 for the cycle.
- `incorrect`, out, 1: to fetch; one-cycle redirect pulse.
- `imm32`, out, 32: to fetch; redirect offset relative to the branch PC; 0 when `incorrect`=0.
- `id_valid`, out, 1: `id_inst` is a live instruction (0 = bubble).
- `id_inst`, out, 32: IF/ID instruction register.
- `id_pc`, out, 32: address of `id_inst`.
- `id_imm`, out, 32: sign-extended immediate of `id_inst` (I/S/B/U/J by opcode; 0 for R-type and unknown opcodes).
- `id_link`, out, 32: `id_pc` + 4.

## Operation

- Registers: `fpc` (address of the word currently on `inst`), `id_inst`, `id_pc`, `id_valid`, state (RUN, SQ), `tgt` (latched redirect target).
- Every posedge: `id_inst`←`inst`, `id_pc`←`fpc`, `fpc`←`fpc`+4. Exceptions are listed below.
- Taken condition, evaluated only when `id_valid`=1 and state=RUN:
  - BEQ/BNE/BLT/BGE/BLTU/BGEU (opcode 1100011): taken when the compare of `rs1_data`,`rs2_data` is true (signed or unsigned per funct3). funct3 010/011 is never taken.
  - JAL (1101111): always taken.
  - JALR (1100111): always taken.
- Offset on a taken transfer:
  - B and JAL: `imm32` = B or J immediate.
  - JALR: `imm32` = ((`rs1_data`+I-imm) & ~1) − `id_pc`, computed mod 2^32.
- `incorrect` = taken; it is combinational from `id_*` and the register data.
- RUN with `incorrect`=1:
  - word captured at this edge gets `id_valid`←0.
  - `tgt`←{(`id_pc`+`imm32`)[31:2],2'b00}.
  - next state SQ.
- SQ (exactly 1 cycle):
  - `stall`=1, `incorrect`=0.
  - captured word (0) gets `id_valid`←0.
  - `fpc`←`tgt`.
  - next state RUN.
- RUN with no redirect: captured word gets `id_valid`←1.
- A taken transfer whose target equals `id_pc`+4 still redirects. There is no shortcut.
- Low two target bits are dropped. There is no misalignment exception.
- Load-use and data hazards are not handled here. EX owns them.

## Timing

- Reset (async assert, any state): `id_valid`=0, `id_inst`=0, `id_pc`=0, `fpc`=`RESET_PC`, state RUN, `tgt`=0.
- Outputs during reset: `stall`=0, `incorrect`=0, `imm32`=0.
- Fetch contract: the word at `RESET_PC` is on `inst` in the first cycle after `rst` deasserts, and each following cycle advances by 4.
- Redirect timing, with the branch in ID during cycle k (`incorrect`=1):
  - the words present in cycles k and k+1 are wrong-path and squashed.
  - the word present in cycle k+2 is at the target.
  - `id_valid`=1 for the target from cycle k+3.
- Redirect penalty is 2 bubbles. The branch itself proceeds to EX with `id_valid`=1 in cycle k.
- `id_valid`=0 in ID suppresses the taken evaluation. A branch cannot be followed by a redirect from a squashed slot.
- `rst` asserted during SQ returns to RUN with no pending redirect, and `stall` drops immediately.

## Test plan

- Reset release, stream of 4 ADDI words:
  - `id_valid`=1 from cycle 2.
  - `id_pc`=0,4,8,12.
  - `stall`=`incorrect`=0 throughout.
- BEQ x1,x2,+16 at PC 8, with x1=x2=5:
  - `incorrect`=1 and `imm32`=16 for one cycle, then `stall`=1 for one cycle.
  - two `id_valid`=0 slots follow.
  - next valid `id_pc`=24.
- BEQ with x1=5, x2=6:
  - no redirect.
  - `id_pc` continues 12,16.
- BLT vs BLTU with x1=32'hFFFF_FFFF and x2=1:
  - BLT is taken.
  - BLTU is not taken.
- JALR x0,4(x5) at PC 40, with x5=32'h0000_0103:
  - `imm32` = 32'h106−40 = 32'hDE.
  - next valid `id_pc` = 32'h104.
  - `id_link`=44.
- Reset pulse mid-SQ:
  - `stall` drops asynchronously.
  - after release, `id_pc` restarts at `RESET_PC`.
  - no spurious `incorrect`.
